// File: rtl/sb_fake_pulse_gen_pkg.sv
// Shared types and constants for the synthetic PMT/SSD pulse generator.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package sb_fake_pulse_gen_pkg;

    localparam int FPG_WIDTH_BITS  = 4;
    localparam int FPG_OFFSET_BITS = 4;
    localparam int FPG_PERIOD_BITS = 24;

    // Longest decaying tail, in bins, after a channel's flat top.
    localparam int FPG_TAIL_MAX    = 8;

    typedef enum logic [1:0] {
        FPG_ST_IDLE  = 2'd0,
        FPG_ST_PULSE = 2'd1,
        FPG_ST_GAP   = 2'd2
    } fpg_state_t;

    // Number of non-zero tail bins for a given amplitude: the excess halves
    // each bin, so the tail lasts until amp >> j reaches zero, capped at
    // FPG_TAIL_MAX bins.
    function automatic logic [3:0] fpg_tail_len(input logic [15:0] amp);
        logic [3:0] len;
        len = 4'd0;
        for (int j = 1; j <= FPG_TAIL_MAX; j++) begin
            if ((amp >> j) != 16'd0) begin
                len = 4'(j);
            end
        end
        return len;
    endfunction

endpackage

// File: rtl/sb_fake_pulse_chan.sv
// One synthetic ADC channel: window compare, saturating add, optional decay tail (FAKE_PULSE_DECAY_EN).
// Latency: one cycle from cnt/active to the registered sample.
// Backpressure: none; produces one sample every clock.
module sb_fake_pulse_chan
    import sb_fake_pulse_gen_pkg::*;
#(
    parameter int ADC_WIDTH   = 12,
    parameter int WIDTH_BITS  = 4,
    parameter int OFFSET_BITS = 4,
    parameter int CNT_BITS    = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   active,
    input  logic                   en,
    input  logic [CNT_BITS-1:0]    cnt,
    input  logic [OFFSET_BITS-1:0] start_bin,
    input  logic [WIDTH_BITS-1:0]  width_m1,
    input  logic [ADC_WIDTH-1:0]   base,
    input  logic [ADC_WIDTH-1:0]   amp,
    output logic [ADC_WIDTH-1:0]   sample
);

    logic [CNT_BITS-1:0]  flat_start;
    logic [CNT_BITS-1:0]  flat_end;
    logic                 in_flat;
    logic [ADC_WIDTH-1:0] excess;
    logic [ADC_WIDTH:0]   sum;

    assign flat_start = CNT_BITS'(start_bin);
    assign flat_end   = flat_start + CNT_BITS'(width_m1);
    assign in_flat    = active && en && (cnt >= flat_start) && (cnt <= flat_end);

`ifdef FAKE_PULSE_DECAY_EN
    logic [CNT_BITS-1:0] tail_pos;
    logic                in_tail;

    assign tail_pos = cnt - flat_end;
    assign in_tail  = active && en && (cnt > flat_end) &&
                      (tail_pos <= CNT_BITS'(FPG_TAIL_MAX));

    // Flat top at full amplitude, then the excess halves every bin.
    always_comb begin
        excess = '0;
        if (in_flat) begin
            excess = amp;
        end else if (in_tail) begin
            excess = amp >> tail_pos;
        end
    end
`else
    // Flat top only; the channel drops straight back to baseline.
    always_comb begin
        excess = '0;
        if (in_flat) begin
            excess = amp;
        end
    end
`endif

    assign sum = {1'b0, base} + {1'b0, excess};

    // Output register, clamped to full scale instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample <= '0;
        end else if (sum[ADC_WIDTH]) begin
            sample <= '1;
        end else begin
            sample <= sum[ADC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/sb_fake_pulse_gen.sv
// Synthetic PMT/SSD rectangular pulse generator feeding the single-bin trigger; optional decay tail under FAKE_PULSE_DECAY_EN.
// Latency: START accepted at edge t gives the first WCD pulse bin at edge t+1, the SSD bin at t+1+SSD_OFFSET.
// Backpressure: none; START is ignored while BUSY or with ENABLE low, ENABLE low stops after the current pulse.
module sb_fake_pulse_gen
    import sb_fake_pulse_gen_pkg::*;
#(
    parameter int ADC_WIDTH   = 12,
    parameter int WIDTH_BITS  = FPG_WIDTH_BITS,
    parameter int OFFSET_BITS = FPG_OFFSET_BITS,
    parameter int PERIOD_BITS = FPG_PERIOD_BITS
) (
    input  logic                   CLK120,
    input  logic                   RESET_N,
    input  logic                   ENABLE,
    input  logic                   START,
    input  logic                   MODE,
    input  logic [3:0]             CHAN_MASK,
    input  logic [ADC_WIDTH-1:0]   BASELINE,
    input  logic [ADC_WIDTH-1:0]   AMP0,
    input  logic [ADC_WIDTH-1:0]   AMP1,
    input  logic [ADC_WIDTH-1:0]   AMP2,
    input  logic [ADC_WIDTH-1:0]   AMP_SSD,
    input  logic [WIDTH_BITS-1:0]  WIDTH_M1,
    input  logic [OFFSET_BITS-1:0] SSD_OFFSET,
    input  logic [PERIOD_BITS-1:0] PERIOD,
    output logic [ADC_WIDTH-1:0]   ADC0,
    output logic [ADC_WIDTH-1:0]   ADC1,
    output logic [ADC_WIDTH-1:0]   ADC2,
    output logic [ADC_WIDTH-1:0]   ADC_SSD,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [31:0]            PULSE_COUNT
);

    // Pulse-bin counter must reach offset + width + longest tail.
    localparam int CNT_BITS = $clog2((1 << OFFSET_BITS) + (1 << WIDTH_BITS) + FPG_TAIL_MAX);

    fpg_state_t             state;
    logic [CNT_BITS-1:0]    cnt;
    logic [PERIOD_BITS-1:0] pcnt;

    // Configuration captured on the accepted START.
    logic                   mode_q;
    logic [3:0]             mask_q;
    logic [ADC_WIDTH-1:0]   base_q;
    logic [ADC_WIDTH-1:0]   amp_q [4];
    logic [WIDTH_BITS-1:0]  w_q;
    logic [OFFSET_BITS-1:0] off_q;
    logic [PERIOD_BITS-1:0] period_q;

    logic [CNT_BITS-1:0]    end_cnt;
    logic [PERIOD_BITS-1:0] min_period;
    logic [PERIOD_BITS-1:0] period_eff;
    logic [ADC_WIDTH-1:0]   chan_base;
    logic                   pulse_active;
    logic [ADC_WIDTH-1:0]   sample [4];

`ifdef FAKE_PULSE_DECAY_EN
    // Last pulse bin: the later of the SSD flat top and every active channel's tail.
    always_comb begin
        logic [CNT_BITS-1:0] cand;
        end_cnt = CNT_BITS'(off_q) + CNT_BITS'(w_q);
        for (int k = 0; k < 3; k++) begin
            cand = CNT_BITS'(w_q) + CNT_BITS'(fpg_tail_len(16'(amp_q[k])));
            if (mask_q[k] && (cand > end_cnt)) begin
                end_cnt = cand;
            end
        end
        cand = CNT_BITS'(off_q) + CNT_BITS'(w_q) + CNT_BITS'(fpg_tail_len(16'(amp_q[3])));
        if (mask_q[3] && (cand > end_cnt)) begin
            end_cnt = cand;
        end
    end
`else
    // Last pulse bin is the end of the SSD flat top, independent of the mask.
    assign end_cnt = CNT_BITS'(off_q) + CNT_BITS'(w_q);
`endif

    // At least one baseline bin separates consecutive pulses; PERIOD=0 lands here too.
    assign min_period   = PERIOD_BITS'(end_cnt) + PERIOD_BITS'(2);
    assign period_eff   = (period_q > min_period) ? period_q : min_period;

    // Baseline follows the live input while idle, the latched copy while running.
    assign chan_base    = (state == FPG_ST_IDLE) ? BASELINE : base_q;
    assign pulse_active = (state == FPG_ST_PULSE);

    // Control FSM: config latch, pulse/gap sequencing, BUSY/DONE/PULSE_COUNT.
    always_ff @(posedge CLK120) begin
        if (!RESET_N) begin
            state       <= FPG_ST_IDLE;
            cnt         <= '0;
            pcnt        <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            PULSE_COUNT <= '0;
            mode_q      <= 1'b0;
            mask_q      <= '0;
            base_q      <= '0;
            w_q         <= '0;
            off_q       <= '0;
            period_q    <= '0;
            for (int k = 0; k < 4; k++) begin
                amp_q[k] <= '0;
            end
        end else begin
            DONE <= 1'b0;
            case (state)
                FPG_ST_IDLE: begin
                    if (START && ENABLE) begin
                        mode_q      <= MODE;
                        mask_q      <= CHAN_MASK;
                        base_q      <= BASELINE;
                        amp_q[0]    <= AMP0;
                        amp_q[1]    <= AMP1;
                        amp_q[2]    <= AMP2;
                        amp_q[3]    <= AMP_SSD;
                        w_q         <= WIDTH_M1;
                        off_q       <= SSD_OFFSET;
                        period_q    <= PERIOD;
                        state       <= FPG_ST_PULSE;
                        cnt         <= '0;
                        pcnt        <= '0;
                        BUSY        <= 1'b1;
                        PULSE_COUNT <= PULSE_COUNT + 32'd1;
                    end
                end
                FPG_ST_PULSE: begin
                    pcnt <= pcnt + PERIOD_BITS'(1);
                    if (cnt == end_cnt) begin
                        // A running pulse always completes; ENABLE only decides what follows.
                        if (!mode_q || !ENABLE) begin
                            state <= FPG_ST_IDLE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            state <= FPG_ST_GAP;
                        end
                    end else begin
                        cnt <= cnt + CNT_BITS'(1);
                    end
                end
                FPG_ST_GAP: begin
                    // Stopping wins over a period boundary in the same cycle.
                    if (!ENABLE) begin
                        state <= FPG_ST_IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else if (pcnt == period_eff - PERIOD_BITS'(1)) begin
                        state       <= FPG_ST_PULSE;
                        cnt         <= '0;
                        pcnt        <= '0;
                        PULSE_COUNT <= PULSE_COUNT + 32'd1;
                    end else begin
                        pcnt <= pcnt + PERIOD_BITS'(1);
                    end
                end
                default: begin
                    state <= FPG_ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    // Three WCD shapers start at bin 0; the SSD shaper starts at SSD_OFFSET.
    for (genvar k = 0; k < 4; k++) begin : g_chan
        localparam bit IS_SSD = (k == 3);
        sb_fake_pulse_chan #(
            .ADC_WIDTH   (ADC_WIDTH),
            .WIDTH_BITS  (WIDTH_BITS),
            .OFFSET_BITS (OFFSET_BITS),
            .CNT_BITS    (CNT_BITS)
        ) u_chan (
            .clk       (CLK120),
            .rst_n     (RESET_N),
            .active    (pulse_active),
            .en        (mask_q[k]),
            .cnt       (cnt),
            .start_bin (IS_SSD ? off_q : {OFFSET_BITS{1'b0}}),
            .width_m1  (w_q),
            .base      (chan_base),
            .amp       (amp_q[k]),
            .sample    (sample[k])
        );
    end

    assign ADC0    = sample[0];
    assign ADC1    = sample[1];
    assign ADC2    = sample[2];
    assign ADC_SSD = sample[3];

endmodule

// File: tb/tb_sb_fake_pulse_gen.sv
// Directed bench for sb_fake_pulse_gen with hand-computed expected samples.
// Latency: inputs change and outputs are sampled 1 ns after each rising edge.
// Backpressure: n/a.
module tb_sb_fake_pulse_gen;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic        mode;
    logic [3:0]  chan_mask;
    logic [11:0] baseline;
    logic [11:0] amp0, amp1, amp2, amp_ssd;
    logic [3:0]  width_m1;
    logic [3:0]  ssd_offset;
    logic [23:0] period;
    logic [11:0] adc0, adc1, adc2, adc_ssd;
    logic        busy;
    logic        done;
    logic [31:0] pulse_count;

    int vectors;
    int miscompares;

    sb_fake_pulse_gen dut (
        .CLK120      (clk),
        .RESET_N     (rst_n),
        .ENABLE      (enable),
        .START       (start),
        .MODE        (mode),
        .CHAN_MASK   (chan_mask),
        .BASELINE    (baseline),
        .AMP0        (amp0),
        .AMP1        (amp1),
        .AMP2        (amp2),
        .AMP_SSD     (amp_ssd),
        .WIDTH_M1    (width_m1),
        .SSD_OFFSET  (ssd_offset),
        .PERIOD      (period),
        .ADC0        (adc0),
        .ADC1        (adc1),
        .ADC2        (adc2),
        .ADC_SSD     (adc_ssd),
        .BUSY        (busy),
        .DONE        (done),
        .PULSE_COUNT (pulse_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_cfg();
        enable     = 1'b1;
        start      = 1'b0;
        mode       = 1'b0;
        chan_mask  = 4'b0000;
        baseline   = 12'd50;
        amp0       = 12'd0;
        amp1       = 12'd0;
        amp2       = 12'd0;
        amp_ssd    = 12'd0;
        width_m1   = 4'd0;
        ssd_offset = 4'd0;
        period     = 24'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Pulse START for exactly one edge; returns just after that edge (edge t).
    task automatic fire();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        set_idle_cfg();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({busy, done, adc0, adc1, adc2, adc_ssd} !== 50'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, adc0, adc1, adc2, adc_ssd});
        end
        vectors++;
        if (pulse_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d expected 0", pulse_count);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (adc0 !== 12'd50 || adc_ssd !== 12'd50) begin
            miscompares++;
            $display("FAIL idle_baseline: got %0d/%0d expected 50/50", adc0, adc_ssd);
        end
        baseline = 12'd77;
        tick();
        tick();
        vectors++;
        if (adc1 !== 12'd77) begin
            miscompares++;
            $display("FAIL idle_live_baseline: got %0d expected 77", adc1);
        end
        enable = 1'b0;
        start  = 1'b1;
        tick();
        tick();
        start  = 1'b0;
        enable = 1'b1;
        vectors++;
        if (busy !== 1'b0 || pulse_count !== 32'd0) begin
            miscompares++;
            $display("FAIL start_disabled: got busy=%0b count=%0d expected busy=0 count=0", busy, pulse_count);
        end
    endtask

    task automatic test_single_shot();
        logic [49:0] obs, exp;
        set_idle_cfg();
        do_reset();
        amp0      = 12'd200;
        amp1      = 12'd77;
        amp_ssd   = 12'd99;
        width_m1  = 4'd2;
        chan_mask = 4'b0001;
        tick();
        fire();
        // Changes while busy must not affect the running pulse.
        amp0     = 12'd10;
        width_m1 = 4'd0;
        baseline = 12'd60;
        vectors++;
        if (busy !== 1'b1 || pulse_count !== 32'd1 || adc0 !== 12'd50) begin
            miscompares++;
            $display("FAIL single_start: got busy=%0b count=%0d adc0=%0d expected 1/1/50", busy, pulse_count, adc0);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            obs = {busy, done, adc0, adc1, adc2, adc_ssd};
            exp = {(i < 3), (i == 3), 12'd250, 12'd50, 12'd50, 12'd50};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL single_shot[%0d]: got %h expected %h", i, obs, exp);
            end
        end
        tick();
        vectors++;
        if ({busy, done, adc0} !== {1'b0, 1'b0, 12'd60}) begin
            miscompares++;
            $display("FAIL single_after: got %h expected %h", {busy, done, adc0}, {1'b0, 1'b0, 12'd60});
        end
        vectors++;
        if (pulse_count !== 32'd1) begin
            miscompares++;
            $display("FAIL single_count: got %0d expected 1", pulse_count);
        end
    endtask

    task automatic test_ssd_offset();
        logic [49:0] obs, exp;
        set_idle_cfg();
        do_reset();
        amp0       = 12'd10;
        amp1       = 12'd20;
        amp2       = 12'd30;
        amp_ssd    = 12'd100;
        width_m1   = 4'd0;
        ssd_offset = 4'd5;
        chan_mask  = 4'b1111;
        tick();
        fire();
        for (int i = 1; i <= 8; i++) begin
            tick();
            obs = {busy, done, adc0, adc1, adc2, adc_ssd};
            exp = {(i < 6), (i == 6),
                   (i == 1) ? 12'd60 : 12'd50,
                   (i == 1) ? 12'd70 : 12'd50,
                   (i == 1) ? 12'd80 : 12'd50,
                   (i == 6) ? 12'd150 : 12'd50};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL ssd_offset[%0d]: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_periodic();
        logic [13:0] obs, exp;
        set_idle_cfg();
        do_reset();
        mode      = 1'b1;
        period    = 24'd10;
        width_m1  = 4'd1;
        amp0      = 12'd100;
        chan_mask = 4'b0001;
        tick();
        fire();
        for (int i = 1; i <= 25; i++) begin
            tick();
            obs = {busy, done, adc0};
            exp = {(i < 22), (i == 22),
                   ((i % 10 == 1 || i % 10 == 2) && i <= 22) ? 12'd150 : 12'd50};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL periodic[%0d]: got %h expected %h", i, obs, exp);
            end
            vectors++;
            if (pulse_count !== 32'(1 + (i >= 10) + (i >= 20))) begin
                miscompares++;
                $display("FAIL periodic_count[%0d]: got %0d expected %0d", i, pulse_count, 1 + (i >= 10) + (i >= 20));
            end
            // Drop ENABLE during the first bin of the third pulse.
            if (i == 20) enable = 1'b0;
        end
        enable = 1'b1;
        mode   = 1'b0;
    endtask

    task automatic test_min_period();
        logic [25:0] obs, exp;
        set_idle_cfg();
        do_reset();
        mode       = 1'b1;
        period     = 24'd1;
        width_m1   = 4'd3;
        ssd_offset = 4'd2;
        amp0       = 12'd100;
        amp_ssd    = 12'd40;
        chan_mask  = 4'b1001;
        tick();
        fire();
        for (int i = 1; i <= 17; i++) begin
            tick();
            obs = {busy, done, adc0, adc_ssd};
            exp = {(i < 14), (i == 14),
                   ((i >= 1 && i <= 4) || (i >= 8 && i <= 11)) ? 12'd150 : 12'd50,
                   ((i >= 3 && i <= 6) || (i >= 10 && i <= 13)) ? 12'd90 : 12'd50};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL min_period[%0d]: got %h expected %h", i, obs, exp);
            end
            vectors++;
            if (pulse_count !== ((i < 7) ? 32'd1 : 32'd2)) begin
                miscompares++;
                $display("FAIL min_period_count[%0d]: got %0d expected %0d", i, pulse_count, (i < 7) ? 1 : 2);
            end
            // ENABLE falls in the last GAP cycle, coinciding with the period boundary.
            if (i == 13) enable = 1'b0;
        end
        enable = 1'b1;
        mode   = 1'b0;
    endtask

    task automatic test_saturation();
        logic [49:0] obs, exp;
        set_idle_cfg();
        do_reset();
        baseline  = 12'd4000;
        amp0      = 12'd95;
        amp1      = 12'd500;
        amp2      = 12'd96;
        amp_ssd   = 12'd3000;
        chan_mask = 4'b0111;
        tick();
        fire();
        for (int i = 1; i <= 2; i++) begin
            tick();
            obs = {busy, done, adc0, adc1, adc2, adc_ssd};
            exp = {1'b0, (i == 1),
                   (i == 1) ? 12'd4095 : 12'd4000,
                   (i == 1) ? 12'd4095 : 12'd4000,
                   (i == 1) ? 12'd4095 : 12'd4000,
                   12'd4000};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL saturation[%0d]: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        set_idle_cfg();
        do_reset();
        amp0      = 12'd100;
        amp1      = 12'd100;
        amp2      = 12'd100;
        amp_ssd   = 12'd100;
        width_m1  = 4'd7;
        chan_mask = 4'b1111;
        tick();
        fire();
        tick();
        tick();
        vectors++;
        if (adc0 !== 12'd150 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pulse_pre: got adc0=%0d busy=%0b expected 150/1", adc0, busy);
        end
        rst_n = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({busy, done, adc0, adc1, adc2, adc_ssd, pulse_count} !== 82'd0) begin
                miscompares++;
                $display("FAIL mid_pulse_reset[%0d]: got busy=%0b done=%0b adc=%0d/%0d/%0d/%0d count=%0d expected all 0",
                         i, busy, done, adc0, adc1, adc2, adc_ssd, pulse_count);
            end
        end
        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({busy, done, adc0, adc1, adc2, adc_ssd} !== {1'b0, 1'b0, 12'd50, 12'd50, 12'd50, 12'd50}) begin
                miscompares++;
                $display("FAIL post_reset_idle[%0d]: got %h expected %h", i,
                         {busy, done, adc0, adc1, adc2, adc_ssd}, {1'b0, 1'b0, 12'd50, 12'd50, 12'd50, 12'd50});
            end
        end
    endtask

`ifdef FAKE_PULSE_DECAY_EN
    task automatic test_decay();
        logic [11:0] tail [9];
        tail = '{12'd114, 12'd82, 12'd66, 12'd58, 12'd54, 12'd52, 12'd51, 12'd50, 12'd50};
        set_idle_cfg();
        do_reset();
        amp0      = 12'd64;
        chan_mask = 4'b0001;
        tick();
        fire();
        for (int i = 1; i <= 9; i++) begin
            tick();
            vectors++;
            if ({done, adc0} !== {(i == 7), tail[i-1]}) begin
                miscompares++;
                $display("FAIL decay[%0d]: got done=%0b adc0=%0d expected done=%0b adc0=%0d",
                         i, done, adc0, (i == 7), tail[i-1]);
            end
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        set_idle_cfg();
        test_reset();
`ifdef FAKE_PULSE_DECAY_EN
        test_reset_mid_pulse();
        test_decay();
`else
        test_single_shot();
        test_ssd_offset();
        test_periodic();
        test_min_period();
        test_saturation();
        test_reset_mid_pulse();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
